uart_rx: RTL and testbench

- Serial-to-parallel UART receiver that sits directly downstream of the host line (`uart_master_tx`) and feeds received bytes into `uart_io`.
- Synchronizes the asynchronous RX line and oversamples it to detect and validate the start bit.
- Samples each data, parity and stop bit at mid-bit.
- Presents each frame on a one-entry valid/ready holding register, with error sideband.

---
 rtl/lotr_pkg.sv | 26 ++
 rtl/uart_baud_gen.sv | 32 +++
 rtl/uart_rx.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lotr_pkg.sv
// Shared UART definitions: receiver FSM state type, default line settings and
// the baud divider calculation used by both the RX and TX sides.
package lotr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } uart_rx_state_t;

  localparam int unsigned UART_DEFAULT_BAUD = 9600;
  localparam int unsigned UART_OVERSAMPLE   = 16;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned den;
    den = baud * os;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator.
//   clk     : system clock
//   rstn    : asynchronous active-low reset
//   restart : zero the divider so the next tick lands DIV clocks later
//   tick    : one-cycle pulse every DIV clocks
module uart_baud_gen #(
  parameter int unsigned DIV = 130
) (
  input  logic clk,
  input  logic rstn,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (restart || cnt_q == CntLast) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == CntLast) && !restart;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes the serial line, validates the start bit at
// mid-bit, samples data/parity/stop bits at mid-bit and presents each frame
// in a one-entry valid/ready holding register with error sideband.
//   clk, rstn         : clock, asynchronous active-low reset
//   uart_rx_in        : asynchronous serial line, idle high
//   rx_data, rx_valid : held word and full flag; rx_ready accepts it
//   rx_parity_err     : parity mismatch of the held word
//   rx_frame_err      : stop bit sampled low for the held word
//   rx_overrun        : sticky, a frame arrived while the register was full
//   overrun_clr       : synchronous clear of rx_overrun (set wins)
//   rx_busy           : receiver FSM is not idle
module uart_rx import lotr_pkg::*; #(
  parameter int unsigned CLK_FREQ_HZ     = 20000000,
  parameter int unsigned BAUDRATE        = UART_DEFAULT_BAUD,
  parameter int unsigned OVERSAMPLE      = UART_OVERSAMPLE,
  parameter int unsigned N_DATA_BITS     = 8,
  parameter int unsigned LSB_FIRST       = 1,
  parameter int unsigned PARITY_EN       = 0,
  parameter int unsigned PARITY_ODD      = 0,
  parameter int unsigned SINGLE_STOP_BIT = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   uart_rx_in,
  output logic [N_DATA_BITS-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   rx_parity_err,
  output logic                   rx_frame_err,
  output logic                   rx_overrun,
  input  logic                   overrun_clr,
  output logic                   rx_busy
);

  localparam int unsigned DIV   = uart_div(CLK_FREQ_HZ, BAUDRATE, OVERSAMPLE);
  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(N_DATA_BITS);
  localparam logic [TickW-1:0] HalfLast = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] FullLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  LastBit  = BitW'(N_DATA_BITS - 1);
  localparam logic             ParOdd   = (PARITY_ODD != 0);

  uart_rx_state_t state_q, state_d;

  logic sync1_q, rx_s, rx_prev_q, fall;
  logic tick, sample, start_edge, load, ovr_set;
  logic [TickW-1:0] tick_cnt_q;
  logic [BitW-1:0] bit_cnt_q;
  logic stop_cnt_q, perr_q, ferr_q, break_q;
  logic [N_DATA_BITS-1:0] shreg_q, rx_data_q;
  logic rx_valid_q, rx_perr_q, rx_ferr_q, rx_overrun_q;

  // Synchronizer and edge-detect flops reset to the idle line level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= uart_rx_in;
      rx_s      <= sync1_q;
      rx_prev_q <= rx_s;
    end
  end

  assign fall = rx_prev_q & ~rx_s;
  // After a framing error the line must return high before a new start counts.
  assign start_edge = (state_q == IDLE) && fall && !break_q;

  uart_baud_gen #(
    .DIV(DIV)
  ) u_baud_gen (
    .clk    (clk),
    .rstn   (rstn),
    .restart(start_edge),
    .tick   (tick)
  );

  // Mid-bit sample point: half a bit into START, a full bit in later states.
  assign sample = tick && (tick_cnt_q == ((state_q == START) ? HalfLast : FullLast));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start_edge) state_d = START;
      START:  if (sample) state_d = rx_s ? IDLE : DATA;
      DATA:   if (sample && bit_cnt_q == LastBit) state_d = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (sample) state_d = STOP;
      STOP:   if (sample && ((SINGLE_STOP_BIT != 0) || stop_cnt_q)) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_busy = (state_q != IDLE);
    load    = (state_q == DONE) && (!rx_valid_q || rx_ready);
    ovr_set = (state_q == DONE) && rx_valid_q && !rx_ready;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      break_q    <= 1'b0;
    end else begin
      if (start_edge) begin
        tick_cnt_q <= '0;
        bit_cnt_q  <= '0;
        stop_cnt_q <= 1'b0;
        perr_q     <= 1'b0;
        ferr_q     <= 1'b0;
      end else if (tick && state_q != IDLE && state_q != DONE) begin
        tick_cnt_q <= sample ? '0 : tick_cnt_q + 1'b1;
      end

      if (sample) begin
        unique case (state_q)
          DATA: begin
            if (LSB_FIRST != 0) shreg_q <= {rx_s, shreg_q[N_DATA_BITS-1:1]};
            else                shreg_q <= {shreg_q[N_DATA_BITS-2:0], rx_s};
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
          PARITY: perr_q <= rx_s != ((^shreg_q) ^ ParOdd);
          STOP: begin
            if (!rx_s) ferr_q <= 1'b1;
            stop_cnt_q <= 1'b1;
          end
          default: ;
        endcase
      end

      if (state_q == DONE) begin
        break_q <= ferr_q;
      end else if (state_q == IDLE && rx_s) begin
        break_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_perr_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      if (load) begin
        rx_valid_q <= 1'b1;
        rx_data_q  <= shreg_q;
        rx_perr_q  <= perr_q;
        rx_ferr_q  <= ferr_q;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      if (ovr_set) begin
        rx_overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        rx_overrun_q <= 1'b0;
      end
    end
  end

  assign rx_valid      = rx_valid_q;
  assign rx_data       = rx_data_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8N1 instance and an 8E1 instance, both run
// with a fast clock (4 clocks per oversample tick) to keep runtime short.
module tb_uart_rx;
  import lotr_pkg::*;

  localparam int unsigned CLK_HZ = UART_DEFAULT_BAUD * UART_OVERSAMPLE * 4;
  localparam int DIV = 4;
  localparam int BIT = UART_OVERSAMPLE * DIV;
  // start half-bit + 8 data + 1 stop, in ticks, plus sync/edge/DONE clocks
  localparam int LAT = (UART_OVERSAMPLE / 2 + UART_OVERSAMPLE * 9) * DIV + 4;

  logic clk, rstn, line, line_p, rx_ready, overrun_clr;
  logic [7:0] rx_data, p_data;
  logic rx_valid, rx_perr, rx_ferr, rx_ovr, rx_busy;
  logic p_valid, p_perr, p_ferr, p_ovr, p_busy;
  logic p_ready, p_clr;

  int cyc;
  int t0;
  int n_checks;
  int n_errs;
  logic [9:0] q_rx[$];
  int q_cyc[$];
  logic [9:0] q_p[$];

  uart_rx #(
    .CLK_FREQ_HZ(CLK_HZ)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .uart_rx_in   (line),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_parity_err(rx_perr),
    .rx_frame_err (rx_ferr),
    .rx_overrun   (rx_ovr),
    .overrun_clr  (overrun_clr),
    .rx_busy      (rx_busy)
  );

  uart_rx #(
    .CLK_FREQ_HZ(CLK_HZ),
    .PARITY_EN  (1)
  ) dut_p (
    .clk          (clk),
    .rstn         (rstn),
    .uart_rx_in   (line_p),
    .rx_data      (p_data),
    .rx_valid     (p_valid),
    .rx_ready     (p_ready),
    .rx_parity_err(p_perr),
    .rx_frame_err (p_ferr),
    .rx_overrun   (p_ovr),
    .overrun_clr  (p_clr),
    .rx_busy      (p_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every handshake as {frame_err, parity_err, data}.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      q_rx.push_back({rx_ferr, rx_perr, rx_data});
      q_cyc.push_back(cyc);
    end
    if (p_valid && p_ready) q_p.push_back({p_ferr, p_perr, p_data});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Drive bits LSB first, one bit period each; call on a negedge.
  task automatic send_bits(input logic [15:0] bits, input int n, input bit to_p);
    for (int i = 0; i < n; i++) begin
      if (to_p) line_p = bits[i];
      else      line   = bits[i];
      if (i == 0) t0 = cyc;
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    send_bits({6'h3f, stop, d, 1'b0}, 10, 1'b0);
  endtask

  task automatic send_par(input logic [7:0] d, input logic par);
    send_bits({5'h1f, 1'b1, par, d, 1'b0}, 11, 1'b1);
  endtask

  task automatic idle(input int bits);
    repeat (bits * BIT) @(negedge clk);
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int lat;
    int cnt;
    bit busy_seen;
    cyc = 0; n_checks = 0; n_errs = 0;
    rstn = 1'b0; line = 1'b1; line_p = 1'b1;
    rx_ready = 1'b1; overrun_clr = 1'b0; p_ready = 1'b1; p_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", rx_valid, 0);
    check_eq("rst_data", rx_data, 0);
    check_eq("rst_busy", rx_busy, 0);
    check_eq("rst_ovr", rx_ovr, 0);
    check_eq("rst_errs", {rx_ferr, rx_perr}, 0);
    rstn = 1'b1;
    idle(1);

    // Single 8N1 frame and its latency from the start edge.
    q_rx.delete(); q_cyc.delete();
    send_byte(8'hA5, 1'b1);
    idle(2);
    check_eq("a5_count", q_rx.size(), 1);
    check_eq("a5_word", q_rx[0], 10'h0A5);
    lat = (q_cyc.size() > 0) ? q_cyc[0] - t0 : -1;
    check_eq("a5_latency", (lat >= LAT - DIV - 4) && (lat <= LAT + DIV + 4), 1);

    // Back-to-back frames.
    q_rx.delete();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    idle(2);
    check_eq("b2b_count", q_rx.size(), 3);
    check_eq("b2b_0", q_rx[0], 10'h000);
    check_eq("b2b_1", q_rx[1], 10'h0FF);
    check_eq("b2b_2", q_rx[2], 10'h03C);
    check_eq("b2b_ovr", rx_ovr, 0);

    // Overrun: second word dropped while the first is held.
    q_rx.delete();
    rx_ready = 1'b0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle(1);
    check_eq("ovr_valid", rx_valid, 1);
    check_eq("ovr_data", rx_data, 8'h11);
    check_eq("ovr_flag", rx_ovr, 1);
    @(posedge clk); #1;
    rx_ready = 1'b1; overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;
    @(negedge clk);
    check_eq("ovr_valid_fall", rx_valid, 0);
    check_eq("ovr_clr", rx_ovr, 0);
    idle(2);
    check_eq("ovr_count", q_rx.size(), 1);
    check_eq("ovr_word", q_rx[0], 10'h011);

    // 0.3-bit glitch must be rejected at the start-bit check.
    q_rx.delete();
    busy_seen = 1'b0;
    line = 1'b0;
    for (int k = 0; k < BIT * 3 / 10; k++) begin
      @(negedge clk);
      if (rx_busy) busy_seen = 1'b1;
    end
    line = 1'b1;
    cnt = BIT * 3 / 10;
    while (rx_busy && cnt < 100) begin
      @(negedge clk);
      if (rx_busy) busy_seen = 1'b1;
      cnt++;
    end
    check_eq("glitch_busy_seen", busy_seen, 1);
    check_eq("glitch_busy_bound", cnt <= UART_OVERSAMPLE / 2 * DIV + 8, 1);
    idle(2);
    check_eq("glitch_no_word", q_rx.size(), 0);

    // Framing error followed by a break, then a clean frame.
    send_byte(8'h5A, 1'b0);
    idle(2);
    line = 1'b1;
    idle(1);
    send_byte(8'h01, 1'b1);
    idle(2);
    check_eq("ferr_count", q_rx.size(), 2);
    check_eq("ferr_word", q_rx[0], 10'h25A);
    check_eq("ferr_next", q_rx[1], 10'h001);

    // Even parity instance: 0x07 needs parity bit 1.
    send_par(8'h07, 1'b1);
    send_par(8'h07, 1'b0);
    idle(2);
    check_eq("par_count", q_p.size(), 2);
    check_eq("par_good", q_p[0], 10'h007);
    check_eq("par_bad", q_p[1], 10'h107);

    // Reset after data bit 3 of 0xC3.
    q_rx.delete();
    send_bits(16'h0006, 5, 1'b0);
    check_eq("mid_busy", rx_busy, 1);
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_valid", rx_valid, 0);
    check_eq("mid_rst_data", rx_data, 0);
    check_eq("mid_rst_busy", rx_busy, 0);
    check_eq("mid_rst_flags", {rx_ovr, rx_ferr, rx_perr}, 0);
    line = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    idle(2);
    check_eq("mid_no_partial", q_rx.size(), 0);
    send_byte(8'hC3, 1'b1);
    idle(2);
    check_eq("c3_count", q_rx.size(), 1);
    check_eq("c3_word", q_rx[0], 10'h0C3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
